i2s_rx_param: RTL and testbench

Parametrised I2S/left-justified serial audio receiver. It oversamples the external bit clock, word-select and data lines on the master clock `mck`, assembles one stereo sample pair per frame, and presents it with a single-cycle valid strobe in the `mck` domain. It sits between the codec-facing pins and the pedal's DSP input. It generalises the fixed 24-bit receiver with four additions: configurable sample width, selectable framing mode, tolerance of short and long slots, and an error flag.

---
 rtl/i2s_rx_param.sv | 136 +++++++++++++
 tb/tb_i2s_rx_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_param.sv
// Parametrised I2S / left-justified receiver: oversamples bck/lrck/sd on mck and
// presents one stereo pair per frame with a single-cycle sample_valid strobe.
//
// state     | meaning
// WAIT_SYNC | discard data until ws goes 1->0 (start of a left slot)
// RUN       | capture left/right slots continuously
module i2s_rx_param #(
  parameter int DATA_W      = 24,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              mck,
  input  logic              reset,
  input  logic              enable,
  input  logic              err_clr,
  input  logic              bck_in,
  input  logic              lrck_in,
  input  logic              sd_in,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  typedef enum logic {WAIT_SYNC = 1'b0, RUN = 1'b1} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, sd_sync;
  logic                   bck_d;
  logic                   rise_q1, rise_q2, ws_q1, ws_q2, sd_q1, sd_q2;
  logic                   ws_prev, left_done;
  logic [CNT_W-1:0]       cnt, cnt_inc, fin_cnt, cnt_start;
  logic [DATA_W-1:0]      sh, sh_ins, fin_sh, sh_start, left_hold;
  logic                   boundary;

  // Rise event is delayed two extra mck cycles together with its ws/sd samples.
  assign boundary = rise_q2 && (ws_q2 != ws_prev);

  always_comb begin
    sh_ins  = sh;
    cnt_inc = (cnt < CNT_MAX) ? cnt + CNT_W'(1) : cnt;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt == CNT_W'(DATA_W - 1 - i)) sh_ins[i] = sd_q2;
    end
  end

  // Philips mode: boundary bit closes the old slot; left-justified: it opens the new one.
  always_comb begin
    if (MODE == 0) begin
      fin_sh    = sh_ins;
      fin_cnt   = cnt_inc;
      sh_start  = '0;
      cnt_start = '0;
    end else begin
      fin_sh    = sh;
      fin_cnt   = cnt;
      sh_start  = {sd_q2, {(DATA_W-1){1'b0}}};
      cnt_start = CNT_W'(1);
    end
  end

  always_ff @(posedge mck) begin
    sample_valid <= 1'b0;
    if (err_clr) frame_err <= 1'b0;

    if (!reset || !enable) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      sd_sync   <= '0;
      bck_d     <= 1'b0;
      rise_q1   <= 1'b0;
      rise_q2   <= 1'b0;
      ws_q1     <= 1'b0;
      ws_q2     <= 1'b0;
      sd_q1     <= 1'b0;
      sd_q2     <= 1'b0;
      ws_prev   <= 1'b0;
      left_done <= 1'b0;
      state     <= WAIT_SYNC;
      cnt       <= '0;
      sh        <= '0;
      left_hold <= '0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], bck_in};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_in};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_in};
      bck_d     <= bck_sync[SYNC_STAGES-1];
      rise_q1   <= bck_sync[SYNC_STAGES-1] & ~bck_d;
      ws_q1     <= lrck_sync[SYNC_STAGES-1];
      sd_q1     <= sd_sync[SYNC_STAGES-1];
      rise_q2   <= rise_q1;
      ws_q2     <= ws_q1;
      sd_q2     <= sd_q1;

      if (rise_q2) begin
        ws_prev <= ws_q2;
        if (state == WAIT_SYNC) begin
          if (ws_prev && !ws_q2) begin
            state     <= RUN;
            sh        <= sh_start;
            cnt       <= cnt_start;
            left_done <= 1'b0;
          end
        end else if (boundary) begin
          sh  <= sh_start;
          cnt <= cnt_start;
          if (fin_cnt != CNT_MAX) frame_err <= 1'b1;
          if (!ws_prev) begin
            left_hold <= fin_sh;
            left_done <= 1'b1;
          end else begin
            left_done <= 1'b0;
            if (left_done) begin
              left_out     <= left_hold;
              right_out    <= fin_sh;
              sample_valid <= 1'b1;
            end
          end
        end else begin
          sh  <= sh_ins;
          cnt <= cnt_inc;
        end
      end
    end

    if (!reset) begin
      left_out  <= '0;
      right_out <= '0;
      frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_param.sv
// Directed bench for i2s_rx_param: three instances (Philips/24, left-justified/24,
// Philips/16) share one serial stream; mck = 8x bck.
module tb_i2s_rx_param;

  logic mck = 1'b0;
  logic reset = 1'b0, enable = 1'b1, err_clr = 1'b0;
  logic bck_in = 1'b0, lrck_in = 1'b0, sd_in = 1'b0;

  logic [23:0] l0, r0, l1, r1;
  logic [15:0] l2, r2;
  logic        sv0, sv1, sv2, fe0, fe1, fe2;

  int n_assert = 0, n_fail = 0, dbl = 0;
  logic i2s_mode = 1'b1, prev_bit = 1'b0, sv0_prev = 1'b0;

  logic [31:0] l0_q[$], r0_q[$], l1_q[$], r1_q[$], l2_q[$], r2_q[$];
  time vt_q[$], bt_q[$];

  always #5 mck = ~mck;

  i2s_rx_param #(.DATA_W(24), .MODE(0), .SYNC_STAGES(2)) u0 (
    .mck(mck), .reset(reset), .enable(enable), .err_clr(err_clr),
    .bck_in(bck_in), .lrck_in(lrck_in), .sd_in(sd_in),
    .left_out(l0), .right_out(r0), .sample_valid(sv0), .frame_err(fe0));

  i2s_rx_param #(.DATA_W(24), .MODE(1), .SYNC_STAGES(2)) u1 (
    .mck(mck), .reset(reset), .enable(enable), .err_clr(err_clr),
    .bck_in(bck_in), .lrck_in(lrck_in), .sd_in(sd_in),
    .left_out(l1), .right_out(r1), .sample_valid(sv1), .frame_err(fe1));

  i2s_rx_param #(.DATA_W(16), .MODE(0), .SYNC_STAGES(2)) u2 (
    .mck(mck), .reset(reset), .enable(enable), .err_clr(err_clr),
    .bck_in(bck_in), .lrck_in(lrck_in), .sd_in(sd_in),
    .left_out(l2), .right_out(r2), .sample_valid(sv2), .frame_err(fe2));

  // Pulse recorder; valid time is the posedge that raised the strobe.
  always @(negedge mck) begin
    if (sv0) begin
      l0_q.push_back(32'(l0));
      r0_q.push_back(32'(r0));
      vt_q.push_back($time - 5);
    end
    if (sv1) begin
      l1_q.push_back(32'(l1));
      r1_q.push_back(32'(r1));
    end
    if (sv2) begin
      l2_q.push_back(32'(l2));
      r2_q.push_back(32'(r2));
    end
    if (sv0 && sv0_prev) dbl++;
    sv0_prev = sv0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic ws, input logic d, input logic mark);
    bck_in  = 1'b0;
    lrck_in = ws;
    sd_in   = d;
    repeat (4) @(negedge mck);
    bck_in = 1'b1;
    if (mark) bt_q.push_back($time + 5);
    repeat (4) @(negedge mck);
  endtask

  // word is MSB-aligned at bit 31; Philips framing delays data by one bck.
  task automatic send_slot(input logic ws, input logic [31:0] word, input int nbits);
    logic [31:0] w;
    logic d;
    w = word;
    for (int i = 0; i < nbits; i++) begin
      d = w[31];
      w = w << 1;
      send_bit(ws, i2s_mode ? prev_bit : d, (ws == 1'b0) && (i == 0));
      prev_bit = d;
    end
  endtask

  task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int nbits);
    send_slot(1'b0, lw, nbits);
    send_slot(1'b1, rw, nbits);
  endtask

  initial begin
    // Reset with inputs toggling
    repeat (4) begin
      @(negedge mck);
      bck_in  = ~bck_in;
      lrck_in = ~lrck_in;
      sd_in   = ~sd_in;
    end
    chk("rst left_out", 32'(l0), 32'h0);
    chk("rst right_out", 32'(r0), 32'h0);
    chk("rst valid u0", 32'(sv0), 32'h0);
    chk("rst err u0", 32'(fe0), 32'h0);
    chk("rst valid u1", 32'(sv1), 32'h0);
    chk("rst err u2", 32'(fe2), 32'h0);
    chk("rst no pulses", l0_q.size(), 32'd0);
    bck_in = 1'b0; lrck_in = 1'b1; sd_in = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge mck);

    // Philips nominal, 32-bit slots
    i2s_mode = 1'b1;
    send_slot(1'b1, 32'h0, 32);
    send_frame(32'h88888800, 32'hF0F0F000, 32);
    send_frame(32'h1F3AF000, 32'h12345600, 32);
    // Left-justified stream, 32-bit slots (its left slot closes the previous pair)
    i2s_mode = 1'b0;
    send_slot(1'b0, 32'h61234500, 32);
    chk("i2s pulses", l0_q.size(), 32'd2);
    chk("i2s P0 left", l0_q[0], 32'h888888);
    chk("i2s P0 right", r0_q[0], 32'hF0F0F0);
    chk("i2s P1 left", l0_q[1], 32'h1F3AF0);
    chk("i2s P1 right", r0_q[1], 32'h123456);
    chk("i2s latency P0", 32'(vt_q[0] - bt_q[1]), 32'd40);
    chk("i2s latency P1", 32'(vt_q[1] - bt_q[2]), 32'd40);
    chk("i2s err", 32'(fe0), 32'h0);
    chk("lj-rx on i2s P0 left", l1_q[0], 32'h444444);
    chk("lj-rx on i2s P0 right", r1_q[0], 32'h787878);
    chk("lj-rx on i2s P1 left", l1_q[1], 32'h0F9D78);
    chk("lj-rx on i2s P1 right", r1_q[1], 32'h091A2B);
    chk("w16 P0 left", l2_q[0], 32'h8888);
    chk("w16 P1 right", r2_q[1], 32'h1234);
    send_slot(1'b1, 32'hABCDEF00, 32);

    // Short slots, Philips 16-bit; next frame 24-bit slots with err_clr mid-left
    i2s_mode = 1'b1;
    send_frame(32'hBEEF0000, 32'h12340000, 16);
    fork
      send_slot(1'b0, 32'hABCDEF00, 24);
      begin
        repeat (20) @(negedge mck);
        chk("lj P2 left", l1_q[2], 32'h612345);
        chk("lj P2 right", r1_q[2], 32'hABCDEF);
        chk("i2s-rx on lj P2 left", l0_q[2], 32'hC2468A);
        chk("i2s-rx on lj P2 right", r0_q[2], 32'h579BDE);
        chk("w16 on lj P2 right", r2_q[2], 32'h579B);
        chk("short pulses", l0_q.size(), 32'd4);
        chk("short P3 left", l0_q[3], 32'hBEEF00);
        chk("short P3 right", r0_q[3], 32'h123400);
        chk("short err u0", 32'(fe0), 32'h1);
        chk("short err u1", 32'(fe1), 32'h1);
        chk("short lj P3 right", r1_q[3], 32'h891A00);
        chk("exact w16 P3 left", l2_q[3], 32'hBEEF);
        chk("exact w16 err", 32'(fe2), 32'h0);
        err_clr = 1'b1;
        @(negedge mck);
        err_clr = 1'b0;
      end
    join
    send_slot(1'b1, 32'h13579000, 24);

    // Reset halfway through a right slot
    send_slot(1'b0, 32'hAAAAAA00, 32);
    chk("long pulses", l2_q.size(), 32'd5);
    chk("long w16 P4 left", l2_q[4], 32'hABCD);
    chk("long w16 P4 right", r2_q[4], 32'h1357);
    chk("err after clr u0", 32'(fe0), 32'h0);
    chk("err after clr u1", 32'(fe1), 32'h0);
    chk("w24 P4 right", r0_q[4], 32'h135790);
    chk("lj P4 right", r1_q[4], 32'h89ABC8);
    fork
      send_slot(1'b1, 32'h55555500, 32);
      begin
        repeat (130) @(negedge mck);
        reset = 1'b0;
        repeat (2) @(negedge mck);
        reset = 1'b1;
      end
    join
    chk("midrst left_out", 32'(l0), 32'h0);
    chk("midrst right_out", 32'(r0), 32'h0);
    send_frame(32'h0A0B0C00, 32'h0D0E0F00, 32);
    chk("midrst no pulse", l0_q.size(), 32'd5);

    // Short frame to set frame_err, then enable drop mid-left-slot
    send_frame(32'hCAFE0000, 32'hF00D0000, 16);
    chk("resync pulses", l0_q.size(), 32'd6);
    chk("resync P5 left", l0_q[5], 32'h0A0B0C);
    chk("resync P5 right", r0_q[5], 32'h0D0E0F);
    chk("resync lj P5 left", l1_q[5], 32'h050586);
    fork
      send_slot(1'b0, 32'h77777700, 32);
      begin
        repeat (60) @(negedge mck);
        enable = 1'b0;
        repeat (10) @(negedge mck);
        chk("en-low err", 32'(fe0), 32'h1);
        chk("en-low left hold", 32'(l0), 32'hCAFE00);
        chk("en-low right hold", 32'(r0), 32'hF00D00);
        chk("en-low valid", 32'(sv0), 32'h0);
        chk("en-low pulses", l0_q.size(), 32'd7);
        enable = 1'b1;
      end
    join
    send_slot(1'b1, 32'h11111100, 32);
    send_frame(32'h24681000, 32'h13579B00, 32);
    chk("en resync no pulse", l0_q.size(), 32'd7);
    send_slot(1'b0, 32'h0, 32);
    chk("en resync pulses", l0_q.size(), 32'd8);
    chk("en resync P7 left", l0_q[7], 32'h246810);
    chk("en resync P7 right", r0_q[7], 32'h13579B);
    chk("en resync err held", 32'(fe0), 32'h1);
    chk("pulse spacing", 32'(dbl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
